// File: rtl/alu_pp_44.sv
// 8-bit, 8-function datapath ALU with carry in/out and an enable qualifier.
// Result and carry are registered; one operation per clock, latency 1.
module alu_pp_44 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Ain,
  input  logic [7:0] Bin,
  input  logic       Carryin,
  input  logic [2:0] op,
  input  logic       alu_enabled,
  output logic       Carryout,
  output logic [7:0] alu_out
);

  typedef enum logic [2:0] {
    OP_ADC = 3'd0,
    OP_SBC = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_INC = 3'd7
  } alu_op_e;

  logic [8:0] w_next;
  logic [8:0] w_a9;
  logic [8:0] w_b9;
  logic [8:0] w_nb9;
  logic [8:0] w_c9;
  logic [7:0] r_out;
  logic       r_carry;

  assign w_a9  = {1'b0, Ain};
  assign w_b9  = {1'b0, Bin};
  assign w_nb9 = {1'b0, ~Bin};
  assign w_c9  = {8'd0, Carryin};

  // {carry, result} packed so the 9th bit of every sum lands in the carry flag
  always_comb begin
    w_next = 9'd0;
    case (alu_op_e'(op))
      OP_ADC:  w_next = w_a9 + w_b9 + w_c9;
      OP_SBC:  w_next = w_a9 + w_nb9 + w_c9;
      OP_AND:  w_next = {1'b0, Ain & Bin};
      OP_OR:   w_next = {1'b0, Ain | Bin};
      OP_XOR:  w_next = {1'b0, Ain ^ Bin};
      OP_SHL:  w_next = {Ain[7], Ain[6:0], Carryin};
      OP_SHR:  w_next = {Ain[0], Carryin, Ain[7:1]};
      OP_INC:  w_next = w_a9 + 9'd1;
      default: w_next = 9'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= 8'h00;
      r_carry <= 1'b0;
    end else if (alu_enabled) begin
      r_out   <= w_next[7:0];
      r_carry <= w_next[8];
    end
  end

  assign alu_out  = r_out;
  assign Carryout = r_carry;

endmodule

// File: tb/tb_alu_pp_44.sv
// Self-checking bench for alu_pp_44: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_alu_pp_44;

  logic       clk;
  logic       rst;
  logic [7:0] Ain;
  logic [7:0] Bin;
  logic       Carryin;
  logic [2:0] op;
  logic       alu_enabled;
  logic       Carryout;
  logic [7:0] alu_out;

  int n_checks;
  int n_errors;
  int exp_val;

  alu_pp_44 dut (
    .clk        (clk),
    .rst        (rst),
    .Ain        (Ain),
    .Bin        (Bin),
    .Carryin    (Carryin),
    .op         (op),
    .alu_enabled(alu_enabled),
    .Carryout   (Carryout),
    .alu_out    (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns carry*256 + result, computed with plain integer arithmetic
  function automatic int ref_alu(int f, int a, int b, int c);
    case (f)
      0: return a + b + c;
      1: return a + (255 - b) + c;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a * 2 + c;
      6: return (a % 2) * 256 + c * 128 + a / 2;
      default: return a + 1;
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got carry=%0d out=%0d, expected carry=%0d out=%0d",
               tag, got / 256, got % 256, want / 256, want % 256);
    end
  endtask

  function automatic int observed();
    if ($isunknown({Carryout, alu_out})) return -1;
    return int'(Carryout) * 256 + int'(alu_out);
  endfunction

  // Drive on the falling edge, clock once, update model, compare after the edge
  task automatic step(input string tag, input int a, input int b, input int c,
                      input int f, input int en, input int r);
    @(negedge clk);
    Ain         = 8'(a);
    Bin         = 8'(b);
    Carryin     = 1'(c);
    op          = 3'(f);
    alu_enabled = 1'(en);
    rst         = 1'(r);
    @(posedge clk);
    #1;
    if (r != 0) exp_val = 0;
    else if (en != 0) exp_val = ref_alu(f, a, b, c);
    check(tag, observed(), exp_val);
  endtask

  task automatic step_k(input string tag, input int a, input int b, input int c,
                        input int f, input int en, input int r, input int want);
    step(tag, a, b, c, f, en, r);
    check({tag, "_const"}, observed(), want);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_val  = 0;
    rst = 1'b1; Ain = 8'd0; Bin = 8'd0; Carryin = 1'b0; op = 3'd0; alu_enabled = 1'b0;

    step_k("reset", 130, 25, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step_k("hold_after_reset", 130, 25, 1, 0, 0, 0, 0);

    step_k("sbc0", 167, 117, 0, 1, 1, 0, 256 + 49);
    step_k("sbc1", 127,  28, 0, 1, 1, 0, 256 + 98);
    step_k("sbc2", 143,  43, 1, 1, 1, 0, 256 + 100);
    step_k("sbc3",  98, 170, 1, 1, 1, 0, 184);
    step_k("sbc_wrap", 0, 1, 1, 1, 1, 0, 255);

    step_k("adc_plain", 74, 0, 0, 0, 1, 0, 74);
    step_k("adc_carry", 200, 100, 1, 0, 1, 0, 256 + 45);
    step_k("adc_wrap", 255, 0, 1, 0, 1, 0, 256);
    step_k("inc", 139, 205, 1, 7, 1, 0, 140);
    step_k("inc_wrap", 255, 17, 1, 7, 1, 0, 256);

    step_k("shl", 208, 77, 1, 5, 1, 0, 256 + 161);
    step_k("shr", 20, 249, 0, 6, 1, 0, 10);

    step_k("and", 8'hF0, 8'h3C, 1, 2, 1, 0, 8'h30);
    step_k("or",  8'hF0, 8'h3C, 1, 3, 1, 0, 8'hFC);
    step_k("xor", 8'hF0, 8'h3C, 1, 4, 1, 0, 8'hCC);

    step_k("hold_load", 167, 117, 0, 1, 1, 0, 256 + 49);
    step_k("hold0", 255, 255, 1, 0, 0, 0, 256 + 49);
    step_k("hold1", 3, 9, 0, 7, 0, 0, 256 + 49);
    step_k("reset_prio", 255, 255, 1, 0, 1, 1, 0);
    step_k("after_reset", 10, 20, 1, 0, 1, 0, 31);

    for (int i = 0; i < 400; i++) begin
      step("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           ($urandom_range(0, 24) == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
